// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered, flow-controlled RV32I decode stage.
// Decoded bundle lives in an output register backed by a one-entry skid
// entry, so in_ready comes straight from a flop.
// Optional feature macro: RV_DECODE_MEXT_EN (accept funct7=0000001 R-type,
// i.e. MUL..REMU). When undefined those encodings decode as illegal.
module rv_decode_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 17,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [OPW-1:0]  opcode,
  output logic [RAW-1:0]  waddr,
  output logic [RAW-1:0]  rs1addr,
  output logic [RAW-1:0]  rs2addr,
  output logic [XLEN-1:0] imm,
  output logic            rs1_enable,
  output logic            rs2_enable,
  output logic            w_enable,
  output logic            imm_enable,
  output logic            jmp_enable,
  output logic            br_enable,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            illegal
);

  // Bundle layout: {pc, opcode, waddr, rs1, rs2, imm, 9 flag bits}
  localparam int BW = (2 * XLEN) + OPW + (3 * RAW) + 9;

  // Major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Instruction fields
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic [6:0]  w_op;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;

  assign w_f7  = in_instr[31:25];
  assign w_f3  = in_instr[14:12];
  assign w_op  = in_instr[6:0];
  assign w_rd  = in_instr[11:7];
  assign w_rs1 = in_instr[19:15];
  assign w_rs2 = in_instr[24:20];

  // Immediate candidates, 32 bits before sign extension to XLEN
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_sh;

  assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u  = {in_instr[31:12], 12'h000};
  assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
  assign w_imm_sh = {27'd0, in_instr[24:20]};

  // Legal funct7/funct3 combinations for register-register ops
  logic w_r_legal;

  // Classify R-type funct7 (base ALU, SUB/SRA, optional M-extension)
  always_comb begin
    w_r_legal = 1'b0;
    if (w_f7 == 7'b0000000) begin
      w_r_legal = 1'b1;
    end else if (w_f7 == 7'b0100000) begin
      w_r_legal = (w_f3 == 3'b000) || (w_f3 == 3'b101);
`ifdef RV_DECODE_MEXT_EN
    end else if (w_f7 == 7'b0000001) begin
      w_r_legal = 1'b1;
`endif
    end else begin
      w_r_legal = 1'b0;
    end
  end

  // Raw per-format decode before the legality mask is applied
  logic [16:0] w_opc;
  logic [31:0] w_imm32;
  logic        w_legal;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_use_rd;
  logic        w_use_imm;
  logic        w_is_jmp;
  logic        w_is_br;
  logic        w_is_ld;
  logic        w_is_st;

  // Major-opcode decode: opcode bundle, immediate format and operand usage
  always_comb begin
    w_opc     = {7'd0, w_f3, w_op};
    w_imm32   = 32'd0;
    w_legal   = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_use_imm = 1'b0;
    w_is_jmp  = 1'b0;
    w_is_br   = 1'b0;
    w_is_ld   = 1'b0;
    w_is_st   = 1'b0;
    case (w_op)
      OP_R: begin
        w_opc     = {w_f7, w_f3, w_op};
        w_legal   = w_r_legal;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
      end
      OP_IMM: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_use_imm = 1'b1;
        if (w_f3 == 3'b001) begin
          w_opc   = {w_f7, w_f3, w_op};
          w_imm32 = w_imm_sh;
          w_legal = (w_f7 == 7'b0000000);
        end else if (w_f3 == 3'b101) begin
          w_opc   = {w_f7, w_f3, w_op};
          w_imm32 = w_imm_sh;
          w_legal = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
        end else begin
          w_imm32 = w_imm_i;
          w_legal = 1'b1;
        end
      end
      OP_LOAD: begin
        w_imm32   = w_imm_i;
        w_legal   = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_use_imm = 1'b1;
        w_is_ld   = 1'b1;
      end
      OP_STORE: begin
        w_imm32   = w_imm_s;
        w_legal   = (w_f3 < 3'b011);
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_imm = 1'b1;
        w_is_st   = 1'b1;
      end
      OP_BRANCH: begin
        w_imm32   = w_imm_b;
        w_legal   = (w_f3 != 3'b010) && (w_f3 != 3'b011);
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_imm = 1'b1;
        w_is_br   = 1'b1;
      end
      OP_JALR: begin
        w_imm32   = w_imm_i;
        w_legal   = (w_f3 == 3'b000);
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
        w_use_imm = 1'b1;
        w_is_jmp  = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_opc     = {10'd0, w_op};
        w_imm32   = w_imm_u;
        w_legal   = 1'b1;
        w_use_rd  = 1'b1;
        w_use_imm = 1'b1;
      end
      OP_JAL: begin
        w_opc     = {10'd0, w_op};
        w_imm32   = w_imm_j;
        w_legal   = 1'b1;
        w_use_rd  = 1'b1;
        w_use_imm = 1'b1;
        w_is_jmp  = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: begin
        w_imm32 = w_imm_i;
        w_legal = 1'b1;
      end
      default: begin
        w_opc   = {w_f7, w_f3, w_op};
        w_legal = 1'b0;
      end
    endcase
  end

  // Final decoded fields; illegal encodings drop every enable and operand
  logic            w_dec_ok;
  logic            w_dec_illegal;
  logic [OPW-1:0]  w_dec_opcode;
  logic [RAW-1:0]  w_dec_waddr;
  logic [RAW-1:0]  w_dec_rs1addr;
  logic [RAW-1:0]  w_dec_rs2addr;
  logic [XLEN-1:0] w_dec_imm;
  logic [8:0]      w_dec_flags;

  assign w_dec_ok      = w_legal && (in_instr[1:0] == 2'b11);
  assign w_dec_illegal = !w_dec_ok;
  assign w_dec_opcode  = OPW'(w_opc);
  assign w_dec_waddr   = (w_dec_ok && w_use_rd)  ? RAW'(w_rd)  : '0;
  assign w_dec_rs1addr = (w_dec_ok && w_use_rs1) ? RAW'(w_rs1) : '0;
  assign w_dec_rs2addr = (w_dec_ok && w_use_rs2) ? RAW'(w_rs2) : '0;
  assign w_dec_imm     = w_dec_ok ? XLEN'(signed'(w_imm32)) : '0;
  // Flag order: rs1, rs2, w, imm, jmp, br, mem_rd, mem_wr, illegal.
  // A destination of x0 never produces a writeback.
  assign w_dec_flags   = {w_dec_ok && w_use_rs1,
                          w_dec_ok && w_use_rs2,
                          w_dec_ok && w_use_rd && (w_rd != 5'd0),
                          w_dec_ok && w_use_imm,
                          w_dec_ok && w_is_jmp,
                          w_dec_ok && w_is_br,
                          w_dec_ok && w_is_ld,
                          w_dec_ok && w_is_st,
                          w_dec_illegal};

  logic [BW-1:0] w_in_bundle;
  assign w_in_bundle = {in_pc, w_dec_opcode, w_dec_waddr, w_dec_rs1addr,
                        w_dec_rs2addr, w_dec_imm, w_dec_flags};

  // Handshake state
  logic          r_out_valid;
  logic [BW-1:0] r_out_bundle;
  logic          r_skid_valid;
  logic [BW-1:0] r_skid_bundle;
  logic          r_in_ready;
  logic          w_in_fire;
  logic          w_out_load;

  // r_in_ready is low exactly while the skid entry is occupied
  assign w_in_fire  = in_valid && r_in_ready && !flush;
  assign w_out_load = !r_out_valid || out_ready;

  // Output register, skid entry and registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_bundle  <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_bundle <= '0;
      r_in_ready    <= 1'b1;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out_bundle <= r_skid_bundle;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_in_fire) begin
        r_out_bundle <= w_in_bundle;
        r_out_valid  <= 1'b1;
        r_in_ready   <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
      end
    end else if (w_in_fire) begin
      r_skid_bundle <= w_in_bundle;
      r_skid_valid  <= 1'b1;
      r_in_ready    <= 1'b0;
    end else begin
      r_in_ready <= !r_skid_valid;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign {out_pc, opcode, waddr, rs1addr, rs2addr, imm,
          rs1_enable, rs2_enable, w_enable, imm_enable,
          jmp_enable, br_enable, mem_rd, mem_wr, illegal} = r_out_bundle;

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered, flow-controlled RV32I decode stage between fetch and register-read/execute.
- Decodes all base formats (R, I-ALU, I-shift, load, JALR, S, B, U, J, FENCE/SYSTEM) into the 17-bit {funct7,funct3,opcode} bundle plus enables and a sign-extended immediate.
- Decoded bundle is held in an output register with a one-entry skid buffer, so in_ready is a register output.

Parameters:
XLEN, 32, data/PC width; imm sign-extended to XLEN (must be ≥32)
OPW, 17, decoded opcode width {f7[6:0],f3[2:0],op[6:0]}
RAW, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  drop all buffered/held instructions
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept (registered)
in_instr  in  32  raw instruction
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
out_pc  out  XLEN  PC of bundle
opcode  out  OPW  decoded opcode
waddr, rs1addr, rs2addr  out  RAW each  register addresses
imm  out  XLEN  sign-extended immediate
rs1_enable, rs2_enable, w_enable, imm_enable  out  1 each  operand/writeback enables
jmp_enable  out  1  JAL/JALR
br_enable  out  1  branch
mem_rd, mem_wr  out  1 each  load/store
illegal  out  1  unsupported encoding

Behaviour:
- Reset (async): out_valid=0, skid empty, in_ready=1; all bundle outputs, including out_pc and imm, = 0.
- Transfers: input on in_valid&in_ready; output on out_valid&out_ready. Latency one cycle from input transfer to out_valid when the output register is empty.
- Output register loads when empty or when draining the same cycle. Otherwise the accepted instruction goes to the skid entry and in_ready drops next cycle.
- When the output drains, the skid entry moves into the output register, and in_ready=1 next cycle.
- Sustained full throughput: 1 instruction/cycle when out_ready=1. Bundle order is preserved. Bundle is stable while out_valid&!out_ready.
- flush: next cycle out_valid=0, skid empty, in_ready=1. An input presented in a flush cycle is discarded.
- Decode is combinational on in_instr and captured at the input transfer.
- opcode: {instr[31:25],instr[14:12],instr[6:0]} for R-type and for SLLI/SRLI/SRAI. {7'b0,instr[14:12],instr[6:0]} for other I/S/B/load/JALR. {10'b0,instr[6:0]} for U/J.
- imm, sign-extended from the top instruction bit to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
  - U: {instr[31:12],12'b0}
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
  - shifts: zero-extended shamt instr[24:20]
  - R: 0
- Enables:
  - R: rs1, rs2, w.
  - I-ALU/shift/load: rs1, imm, w. Load also sets mem_rd.
  - JALR: rs1, imm, w, jmp.
  - S: rs1, rs2, imm, mem_wr, no w.
  - B: rs1, rs2, imm, br.
  - LUI/AUIPC: imm, w.
  - JAL: imm, w, jmp.
  - FENCE/SYSTEM: no enables.
  - Unused address fields are 0.
- w_enable is forced 0 when instr[11:7]=0; waddr still reports 0.
- illegal=1 with all enables 0 for any of:
  - unknown major opcode
  - R-type funct7 other than 0000000, or 0100000 only with f3 000/101
  - shift funct7 mismatch (SLLI, SRLI need 0000000; SRAI needs 0100000)
  - load f3 011/110/111
  - store f3 ≥011
  - branch f3 010/011
  - JALR f3≠000
  - instr[1:0]≠11
- An illegal instruction still flows through the handshake.

Optional Feature:
- Macro: RV_DECODE_MEXT_EN.
- Defined: R-type funct7=0000001 (MUL..REMU, all f3) is legal, decoded as R-type with opcode {0000001,f3,0110011}.
- Undefined: such encodings set illegal=1.

Test Plan:
- Reset mid-stream with out_valid=1, skid full → same cycle out_valid=0, in_ready=1, opcode=0, imm=0.
- ADDI x5,x6,-1 (0xFFF30293), out_ready=1 → next cycle opcode=0x00013, rs1addr=6, waddr=5, imm=0xFFFFFFFF, w/imm/rs1 enables=1.
- Back-to-back SW x2,8(x1) (0x0020A423) then BEQ x1,x2,-4 (0xFE208EE3) with out_ready=0 for 2 cycles:
  - store bundle held, imm=8, mem_wr=1, w_enable=0
  - in_ready=0 after second accept
  - branch emerges after release with imm=0xFFFFFFFC, br_enable=1
- JAL x0,+2048 (0x0010006F) → jmp_enable=1, w_enable=0, imm=0x00000800. SRAI x3,x3,4 (0x4041D193) → opcode={0100000,101,0010011}, imm=4.
- MUL x1,x2,x3 (0x023100B3) → illegal=1 without RV_DECODE_MEXT_EN; illegal=0, rs1/rs2/w enables=1 with it. 0x0000000B → illegal=1.
- flush asserted with skid full and in_valid=1 → next cycle out_valid=0, in_ready=1; no bundle from before or during flush ever appears.
